// File: rtl/inst_mem_responder.sv
// Instruction memory responder: a small word-addressed instruction store that
// answers fetch requests after a fixed number of wait states, supports abort
// on branch (flush), and is loaded through a dedicated write port.
//
// state | meaning
// IDLE  | no fetch outstanding, ready to accept a request
// BUSY  | fetch accepted, counting down wait states; fetch stage frozen
// DONE  | fetched word presented on instruction, valid pulses this cycle
module inst_mem_responder #(
  parameter int N     = 32,
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             pc,
  input  logic                     req,
  input  logic                     flush,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [N-1:0]             ld_data,
  output logic [N-1:0]             instruction,
  output logic                     valid,
  output logic                     freeze
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_pc_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_accept;
  logic          w_enter_done;
  logic [N-1:0]  r_instr;
  logic [N-1:0]  r_mem [DEPTH];
  logic          w_unused_pc;

  // Byte address to word index; high bits wrap, byte-offset bits are ignored.
  assign w_pc_idx    = pc[AW+1:2];
  assign w_unused_pc = ^{pc[N-1:AW+2], pc[1:0]};

  // With zero wait states the fetch goes straight to DONE on the accept edge,
  // so the read must use the incoming index rather than the latched one.
  assign w_rd_idx     = w_accept ? w_pc_idx : r_idx;
  assign w_enter_done = (w_state_nxt == DONE);

  // State and wait-state counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    valid       = 1'b0;
    freeze      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_accept = req & ~flush;
      end
      BUSY: begin
        freeze = 1'b1;
        if (flush) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt <= 4'd1) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      DONE: begin
        valid       = ~flush;
        w_state_nxt = IDLE;
        w_accept    = req & ~flush;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
    if (w_accept) begin
      w_cnt_nxt   = WAIT_CNT;
      w_state_nxt = (WAIT_CNT != 4'd0) ? BUSY : DONE;
    end
  end

  // Latch the word index of an accepted fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= w_pc_idx;
    end
  end

  // Capture the fetched word on every entry into DONE; holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= '0;
    end else if (w_enter_done) begin
      r_instr <= r_mem[w_rd_idx];
    end
  end

  // Load port; memory has no reset and reads on the same edge see old data.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  assign instruction = r_instr;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: two instances (WAIT=2 and WAIT=0) share one
// stimulus stream; a transaction-level model predicts outputs for both.
module tb_inst_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        req;
  logic        flush;
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] instr2, instr0;
  logic        valid2, valid0;
  logic        freeze2, freeze0;

  int errors = 0;
  int checks = 0;

  inst_mem_responder #(.N(32), .DEPTH(64), .WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .pc(pc), .req(req), .flush(flush),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .instruction(instr2), .valid(valid2), .freeze(freeze2)
  );

  inst_mem_responder #(.N(32), .DEPTH(64), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .pc(pc), .req(req), .flush(flush),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .instruction(instr0), .valid(valid0), .freeze(freeze0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a fetch accepted at the edge closing cycle c is due in cycle
  // c+W+1; it is frozen before that, and the word is read on the edge before.
  logic [31:0] m_mem [64];
  logic        m_pend [2];
  int          m_due  [2];
  logic [5:0]  m_idx  [2];
  logic [31:0] m_ei   [2];
  int          cyc = 0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0;
      m_due[k]  = 0;
      m_idx[k]  = '0;
      m_ei[k]   = '0;
    end
  end

  // Model update once per edge, or immediately on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k] = 1'b0;
        m_ei[k]   = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int w;
        w = (k == 0) ? 2 : 0;
        if (m_pend[k] && cyc < m_due[k] && flush) m_pend[k] = 1'b0;
        if (m_pend[k] && cyc == m_due[k]) m_pend[k] = 1'b0;
        if (!m_pend[k] && req && !flush) begin
          m_pend[k] = 1'b1;
          m_due[k]  = cyc + w + 1;
          m_idx[k]  = pc[7:2];
        end
        if (m_pend[k] && m_due[k] == cyc + 1) m_ei[k] = m_mem[m_idx[k]];
      end
      if (ld_en) m_mem[ld_addr] = ld_data;
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h time=%0t", nm, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("w2_valid",  {31'b0, valid2},  {31'b0, m_pend[0] && cyc == m_due[0] && !flush});
      chk("w2_freeze", {31'b0, freeze2}, {31'b0, m_pend[0] && cyc < m_due[0]});
      chk("w2_instr",  instr2, m_ei[0]);
      chk("w0_valid",  {31'b0, valid0},  {31'b0, m_pend[1] && cyc == m_due[1] && !flush});
      chk("w0_freeze", {31'b0, freeze0}, {31'b0, m_pend[1] && cyc < m_due[1]});
      chk("w0_instr",  instr0, m_ei[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Single WAIT=2 fetch, checking the DONE cycle against a literal.
  task automatic fetch2(input logic [31:0] a, input logic [31:0] exp, input string nm);
    req = 1'b1; pc = a;
    tick();
    req = 1'b0;
    tick();
    tick();
    #1;
    chk({nm, "_valid"}, {31'b0, valid2}, 32'd1);
    chk({nm, "_instr"}, instr2, exp);
    tick();
  endtask

  initial begin
    rst = 1'b0; pc = '0; req = 1'b0; flush = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_instr",  instr2, 32'h0);
    chk("rst_valid",  {31'b0, valid2}, 32'd0);
    chk("rst_freeze", {31'b0, freeze2}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Fill memory; the first six words are fixed for the directed checks.
    for (int i = 0; i < 64; i++) begin
      ld_en = 1'b1; ld_addr = 6'(i);
      case (i)
        0: ld_data = 32'h1111_1111;
        1: ld_data = 32'h2222_2222;
        2: ld_data = 32'h3333_3333;
        3: ld_data = 32'hE3A0_1005;
        4: ld_data = 32'h4444_4444;
        5: ld_data = 32'h0000_0000;
        default: ld_data = $urandom;
      endcase
      tick();
    end
    ld_en = 1'b0;

    // Basic fetch of word 3 with two wait states.
    req = 1'b1; pc = 32'h0000_000C;
    tick();
    req = 1'b0; #1;
    chk("c1_freeze", {31'b0, freeze2}, 32'd1);
    chk("c1_valid",  {31'b0, valid2},  32'd0);
    chk("w0_c1_valid", {31'b0, valid0}, 32'd1);
    chk("w0_c1_instr", instr0, 32'hE3A0_1005);
    tick(); #1;
    chk("c2_freeze", {31'b0, freeze2}, 32'd1);
    tick(); #1;
    chk("c3_valid",  {31'b0, valid2},  32'd1);
    chk("c3_instr",  instr2, 32'hE3A0_1005);
    chk("c3_freeze", {31'b0, freeze2}, 32'd0);
    tick(); #1;
    chk("c4_valid",  {31'b0, valid2},  32'd0);

    // Back-to-back fetches with zero wait states.
    req = 1'b1; pc = 32'h0;
    tick(); pc = 32'h4; #1;
    chk("b2b0_valid", {31'b0, valid0}, 32'd1);
    chk("b2b0_instr", instr0, 32'h1111_1111);
    tick(); pc = 32'h8; #1;
    chk("b2b1_valid", {31'b0, valid0}, 32'd1);
    chk("b2b1_instr", instr0, 32'h2222_2222);
    chk("b2b1_freeze", {31'b0, freeze0}, 32'd0);
    tick(); req = 1'b0; #1;
    chk("b2b2_valid", {31'b0, valid0}, 32'd1);
    chk("b2b2_instr", instr0, 32'h3333_3333);
    tick(); tick(); tick();

    // Flush while busy leaves the previous instruction in place.
    fetch2(32'h8, 32'h3333_3333, "pre_flush");
    req = 1'b1; pc = 32'h10;
    tick();
    req = 1'b0; flush = 1'b1; #1;
    chk("fl_c1_freeze", {31'b0, freeze2}, 32'd1);
    tick();
    flush = 1'b0; #1;
    chk("fl_c2_freeze", {31'b0, freeze2}, 32'd0);
    chk("fl_c2_valid",  {31'b0, valid2},  32'd0);
    chk("fl_c2_instr",  instr2, 32'h3333_3333);
    tick(); #1;
    chk("fl_c3_valid",  {31'b0, valid2},  32'd0);
    chk("fl_c3_instr",  instr2, 32'h3333_3333);
    tick();

    // Address wrap and ignored byte offset.
    fetch2(32'h0000_0104, 32'h2222_2222, "wrap104");
    fetch2(32'h0000_0200, 32'h1111_1111, "wrap200");
    fetch2(32'h0000_0107, 32'h2222_2222, "wrap107");

    // Load to the word being read on the DONE-entry edge returns old data.
    req = 1'b1; pc = 32'h14;
    tick();
    req = 1'b0;
    tick();
    ld_en = 1'b1; ld_addr = 6'd5; ld_data = 32'h1;
    tick();
    ld_en = 1'b0; #1;
    chk("rbw_valid", {31'b0, valid2}, 32'd1);
    chk("rbw_instr", instr2, 32'h0);
    tick();
    fetch2(32'h14, 32'h1, "rbw_new");

    // Asynchronous reset mid-BUSY.
    req = 1'b1; pc = 32'h0C;
    tick();
    req = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_freeze", {31'b0, freeze2}, 32'd0);
    chk("arst_valid",  {31'b0, valid2},  32'd0);
    chk("arst_instr",  instr2, 32'h0);
    chk("arst_instr0", instr0, 32'h0);
    rst = 1'b0;
    tick(); #1;
    chk("arst_nv2", {31'b0, valid2}, 32'd0);
    tick(); #1;
    chk("arst_nv3", {31'b0, valid2}, 32'd0);
    tick();

    // First request right after reset release, memory intact.
    rst = 1'b1; #1 rst = 1'b0;
    fetch2(32'h0C, 32'hE3A0_1005, "post_rst");

    // Randomized traffic, including occasional short async reset pulses.
    for (int i = 0; i < 800; i++) begin
      req     = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 5) == 0);
      pc      = $urandom;
      ld_en   = ($urandom_range(0, 4) == 0);
      ld_addr = 6'($urandom_range(0, 63));
      ld_data = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end
    req = 1'b0; flush = 1'b0; ld_en = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_responder.md
INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 The block SHALL have parameter N, default 32: instruction/address width.
REQ-002 The block SHALL have parameter DEPTH, default 64: instruction words stored, power of two.
REQ-003 The block SHALL have parameter WAIT, default 2: wait-state cycles per fetch, range 0..15.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port pc, input, N: byte address from fetch stage.
REQ-007 Port req, input, 1: fetch request.
REQ-008 Port flush, input, 1: abort outstanding fetch (branch taken).
REQ-009 Port ld_en, input, 1: memory load write enable.
REQ-010 Port ld_addr, input, log2(DEPTH): word address for load.
REQ-011 Port ld_data, input, N: load data.
REQ-012 Port instruction, output, N: fetched instruction, registered.
REQ-013 Port valid, output, 1: instruction valid, one-cycle pulse per completed fetch.
REQ-014 Port freeze, output, 1: fetch stage must hold its PC.

Function
REQ-015 Word index SHALL be pc[log2(DEPTH)+1:2]; pc[1:0] and upper bits ignored (address wraps modulo DEPTH).
REQ-016 FSM states SHALL be IDLE, BUSY, DONE.
REQ-017 IDLE: req=1 and flush=0 -> latch word index, load wait counter with WAIT; next state BUSY if WAIT>0, else DONE.
REQ-018 IDLE: req=0 or flush=1 -> remain IDLE, nothing latched.
REQ-019 BUSY: counter decrements each cycle; counter reaching 1 with flush=0 -> DONE.
REQ-020 BUSY: flush=1 -> IDLE next cycle, counter cleared, no valid produced.
REQ-021 Transition into DONE SHALL register mem[latched index] into instruction.
REQ-022 DONE: valid = 1 and flush = 0 (combinational on state and flush); exactly one cycle.
REQ-023 DONE: req=1 and flush=0 -> accept new fetch as in IDLE (back-to-back); otherwise -> IDLE.
REQ-024 freeze SHALL be 1 exactly while state is BUSY; 0 in IDLE and DONE.
REQ-025 Latency: req accepted at edge t -> valid high during cycle t+WAIT+1; throughput one fetch per WAIT+1 cycles.
REQ-026 instruction SHALL hold last fetched value until next transition into DONE; flush does not clear it.
REQ-027 ld_en=1 SHALL write ld_data to mem[ld_addr] at the clock edge, in any state.
REQ-028 Load and read of same word on the same edge SHALL return old data (read-before-write).
REQ-029 req and flush both high in IDLE/DONE: flush wins, no fetch accepted.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, counter 0, instruction 0, valid 0, freeze 0, regardless of clock.
REQ-031 Reset mid-BUSY SHALL discard the outstanding fetch; no valid after release.
REQ-032 Memory contents SHALL NOT be affected by rst.
REQ-033 First req after rst deassertion SHALL be accepted on the first rising edge.

Verification
REQ-034 Load mem[3]=32'hE3A01005, WAIT=2, req with pc=32'h0C at edge 0 -> freeze 1 cycles 1-2, valid and instruction=32'hE3A01005 in cycle 3.
REQ-035 WAIT=0, req held high, pc=0,4,8 successive -> valid every cycle from cycle 1, freeze never high, instructions mem[0],mem[1],mem[2].
REQ-036 WAIT=2, req at edge 0, flush during cycle 1 -> state IDLE cycle 2, freeze 0, no valid pulse, instruction unchanged.
REQ-037 pc=32'h0000_0104 with DEPTH=64 -> returns mem[1] (wrap); pc=32'h0000_0107 -> also mem[1].
REQ-038 Assert rst asynchronously mid-BUSY -> freeze, valid, instruction go 0 without a clock edge; memory contents still readable afterwards.
REQ-039 ld_en writing mem[5]=32'h1 on the edge entering DONE for index 5 (old 32'h0) -> instruction=32'h0; next fetch of index 5 -> 32'h1.
